button_pulse: RTL and testbench
===============================

# button_pulse

Front-end conditioning stage that drives the `enable` input of the 4-bit counter. Takes a raw, asynchronous, bouncing push-button level. Synchronises and debounces it. Emits exactly one single-cycle `pulse` per debounced press, so each press advances the counter by one. With auto-repeat enabled, holding the button produces further pulses at a programmed rate.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles the synchronised input must differ from `level` before `level` flips. Legal range is 2 or more.
- `REPEAT_EN`, default 1: 1 enables auto-repeat while held; 0 gives one pulse per press only.
- `REPEAT_DELAY`, default 1000: cycles from the press pulse to the first repeat pulse. Legal range is 2 or more.
- `REPEAT_PERIOD`, default 200: cycles between successive repeat pulses. Legal range is 2 or more.

Ports:
- `clk`  input  1  clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `btn_in`  input  1  raw button level; asynchronous; 1 = pressed.
- `pulse`  output  1  one-cycle, registered press/repeat strobe; connects to the counter `enable`.
- `level`  output  1  registered debounced button state.
- `held`  output  1  registered; high while in the REPEAT state.

## Operation
- **Synchroniser:** two flops, `btn_in` → `s1` → `btn_s`. No logic between the two flops.
- **Debounce counter `dcnt`:**
  - Width is `$clog2(DEBOUNCE_CYCLES)`.
  - Cleared whenever `btn_s == level`.
  - Otherwise increments by 1.
  - When `btn_s != level` and `dcnt == DEBOUNCE_CYCLES-1`: `level` toggles and `dcnt` clears on that edge.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles clears `dcnt` and causes no `level` change.
- **FSM states:** IDLE, HOLD, REPEAT.
  - **IDLE → HOLD:** on the edge where `level` goes 0→1. `pulse` is 1 in the following cycle. The repeat counter `rcnt` clears.
  - **HOLD:**
    - `rcnt` increments each cycle.
    - When `rcnt == REPEAT_DELAY-1` and `REPEAT_EN == 1`: emit `pulse`, clear `rcnt`, go to REPEAT.
    - With `REPEAT_EN == 0`: stay in HOLD and never emit a repeat pulse.
  - **REPEAT:**
    - `rcnt` increments.
    - When `rcnt == REPEAT_PERIOD-1`: emit `pulse` and clear `rcnt`.
    - `held` = 1 while in this state.
  - **HOLD or REPEAT → IDLE:** on the edge where `level` goes 1→0. No pulse. `rcnt` clears.
- **Release wins over repeat:** if the release edge coincides with a repeat terminal count, no pulse is emitted and the state goes to IDLE.
- **Repeat counter `rcnt` width:** `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD))`. It never wraps, because it clears at its terminal count.
- **Pulse spacing:** `pulse` is never high for two consecutive cycles, because every parameter is 2 or more.

## Timing
- **Reset values:** while `reset = 1` at an edge, all flops take their reset values:
  - `s1`, `btn_s`, `level`, `pulse`, `held` = 0
  - `dcnt`, `rcnt` = 0
  - state = IDLE
- **Reset mid-operation:**
  - Reset overrides all other activity, including a pending pulse.
  - A button held through reset release is seen as a new press, producing one pulse after the full latency below.
- **Press latency:** let E0 be the first edge sampling `btn_in` = 1, with the input stable thereafter.
  - `btn_s` = 1 after E0+1.
  - `level` and `pulse` = 1 after edge E0+1+`DEBOUNCE_CYCLES`.
  - `pulse` drops after the next edge.
- **Release latency:** the same, `1+DEBOUNCE_CYCLES` edges from the first low sample to `level` = 0.
- **First repeat:** `pulse` rises `REPEAT_DELAY` cycles after the press pulse.
- **Subsequent repeats:** every `REPEAT_PERIOD` cycles.
- **Output timing:** all outputs are registered, with no combinational path from `btn_in` to any output.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES` = 4, `REPEAT_DELAY` = 10, `REPEAT_PERIOD` = 3, `REPEAT_EN` = 1. The counter is instantiated downstream.

- **Clean press:** hold `btn_in` = 1 from edge 0 for 8 cycles, then release.
  - `level` and `pulse` rise after edge 5.
  - `pulse` is high for exactly 1 cycle.
  - Counter reads 1.
  - `level` falls 5 edges after release.
- **Bounce:** toggle `btn_in` with high/low runs of 1, 2, 3, then hold high.
  - Exactly one pulse, 5 edges after the stable-high start.
  - No early `level` change.
  - Counter reads 1.
- **Auto-repeat:** hold for 30 cycles after `level` rises.
  - Pulses occur at press+0, +10, +13, +16, +19, +22, +25, +28.
  - `held` = 1 from the +10 pulse until `level` falls.
  - Counter reads 8.
- **Release on repeat terminal count:** drop `btn_in` so `level` falls on the same edge a repeat pulse would occur.
  - No pulse is emitted.
  - State goes to IDLE and `held` = 0.
- **Reset mid-press:** assert `reset` for 2 cycles while in REPEAT with `btn_in` still high.
  - All outputs are 0 during reset.
  - One new press pulse arrives 5 edges after reset deasserts.
- **`REPEAT_EN` = 0:** hold for 50 cycles.
  - Exactly one pulse.
  - `held` stays 0.
  - Counter reads 1.

Source files
------------

// File: rtl/button_pulse.sv
// button_pulse: conditions a raw, bouncing push-button into a single-cycle
// strobe per debounced press, with optional auto-repeat while held.
//
// Ports:
//   clk     - clock, all logic on the rising edge
//   reset   - synchronous, active-high reset
//   btn_in  - raw asynchronous button level (1 = pressed)
//   pulse   - registered one-cycle press/repeat strobe (counter enable)
//   level   - registered debounced button state
//   held    - registered, high while auto-repeating
module button_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 1000,
  parameter int unsigned REPEAT_PERIOD   = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse,
  output logic level,
  output logic held
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic          s1_q;
  logic          btn_s_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  state_t        state_q, state_d;
  logic          pulse_q, pulse_d;
  logic          held_q, held_d;
  logic          rise;
  logic          fall;

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    dcnt_d  = '0;
    level_d = level_q;
    if (btn_s_q != level_q) begin
      if (dcnt_q == DCNT_LAST) begin
        level_d = ~level_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // Edge events are taken from level_d so the press pulse lines up with the level flip
  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  // Press / repeat FSM; a release always beats a coincident repeat terminal count
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HOLD;
          rcnt_d  = '0;
          pulse_d = 1'b1;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == DELAY_LAST) begin
          // Without auto-repeat the counter parks here instead of wrapping
          if (REPEAT_EN) begin
            state_d = REPEAT;
            rcnt_d  = '0;
            pulse_d = 1'b1;
          end
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == PERIOD_LAST) begin
          rcnt_d  = '0;
          pulse_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
    held_d = (state_d == REPEAT);
  end

  // State registers, including the two-flop synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
      dcnt_q  <= '0;
      level_q <= 1'b0;
      rcnt_q  <= '0;
      state_q <= IDLE;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      s1_q    <= btn_in;
      btn_s_q <= s1_q;
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;
  assign held  = held_q;

endmodule

// File: tb/tb_button_pulse.sv
// tb_button_pulse: self-checking bench for button_pulse. A table of press
// scenarios drives the button; expected pulse cycles are queued when the press
// is driven and popped as the DUT strobes. A second instance checks REPEAT_EN=0.
module tb_button_pulse;

  localparam int DC  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = DC + 2;  // drive cycle to level/pulse cycle

  logic clk;
  logic reset;
  logic btn_in;
  logic btn2;
  logic pulse, level, held;
  logic pulse2, level2, held2;

  int   cyc;
  int   tests;
  int   fails;
  int   q1[$];
  int   q2[$];
  int   cnt1;
  int   cnt2;
  logic prev1;
  logic prev2;

  typedef struct {
    int bounce;
    int hold;
    int exp_count;
    int exp_held;
  } vec_t;

  vec_t vecs[7];

  button_pulse #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_in(btn_in),
    .pulse (pulse),
    .level (level),
    .held  (held)
  );

  button_pulse #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_EN      (1'b0),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut_norep (
    .clk   (clk),
    .reset (reset),
    .btn_in(btn2),
    .pulse (pulse2),
    .level (level2),
    .held  (held2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  // Advance one edge, sample just after it, and reconcile pulses with the queues
  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    cyc++;
    e = -1;
    if (q1.size() > 0 && q1[0] <= cyc) e = q1.pop_front();
    if (pulse || e >= 0) check("pulse_at", pulse ? cyc : -1, e);
    if (pulse) begin
      check("pulse_single_cycle", int'(prev1), 0);
      cnt1++;
    end
    prev1 = pulse;
    e = -1;
    if (q2.size() > 0 && q2[0] <= cyc) e = q2.pop_front();
    if (pulse2 || e >= 0) check("norep_pulse_at", pulse2 ? cyc : -1, e);
    if (pulse2) begin
      check("norep_pulse_single_cycle", int'(prev2), 0);
      cnt2++;
    end
    prev2 = pulse2;
  endtask

  task automatic expect_out(input int exp_level, input int exp_held);
    check("level", int'(level), exp_level);
    check("held", int'(held), exp_held);
  endtask

  task automatic run_vec(input vec_t v, output int seen_held);
    int c;
    int f;
    cnt1      = 0;
    seen_held = 0;
    if (v.bounce != 0) begin
      for (int r = 1; r <= 3; r++) begin
        btn_in = 1'b1;
        repeat (r) begin tick(); expect_out(0, 0); end
        btn_in = 1'b0;
        repeat (r) begin tick(); expect_out(0, 0); end
      end
    end
    c      = cyc;
    btn_in = 1'b1;
    f      = c + v.hold + LAT;
    q1.push_back(c + LAT);
    for (int t = c + LAT + RD; t < f; t += RP) q1.push_back(t);
    for (int rel = 1; rel <= v.hold + LAT + 6; rel++) begin
      tick();
      expect_out(int'(cyc >= c + LAT && cyc < f),
                 int'(v.hold > RD && cyc >= c + LAT + RD && cyc < f));
      if (held) seen_held = 1;
      if (rel == v.hold) btn_in = 1'b0;
    end
    check("pulse_count", cnt1, v.exp_count);
    check("queue_drained", q1.size(), 0);
  endtask

  initial begin
    int c;
    int sh;
    vecs[0] = '{0, 8, 1, 0};   // clean press
    vecs[1] = '{1, 8, 1, 0};   // bounce then stable press
    vecs[2] = '{0, 10, 1, 0};  // release on first-repeat terminal count
    vecs[3] = '{0, 11, 2, 1};  // one repeat, then release
    vecs[4] = '{0, 13, 2, 1};  // release on a REPEAT terminal count
    vecs[5] = '{0, 30, 8, 1};  // auto-repeat, level high 30 cycles
    vecs[6] = '{0, 31, 8, 1};  // release exactly on a repeat slot

    reset  = 1'b1;
    btn_in = 1'b0;
    btn2   = 1'b0;
    cyc    = 0;
    tests  = 0;
    fails  = 0;
    cnt1   = 0;
    cnt2   = 0;
    prev1  = 1'b0;
    prev2  = 1'b0;

    repeat (3) tick();
    check("rst_pulse", int'(pulse), 0);
    check("rst_level", int'(level), 0);
    check("rst_held", int'(held), 0);
    check("rst_norep_pulse", int'(pulse2), 0);
    check("rst_norep_level", int'(level2), 0);
    check("rst_norep_held", int'(held2), 0);
    reset = 1'b0;
    repeat (4) begin tick(); expect_out(0, 0); end

    foreach (vecs[i]) begin
      run_vec(vecs[i], sh);
      check("held_seen", sh, vecs[i].exp_held);
    end

    // Reset while auto-repeating with the button still down
    cnt1   = 0;
    c      = cyc;
    btn_in = 1'b1;
    q1.push_back(c + LAT);
    q1.push_back(c + LAT + RD);
    for (int rel = 1; rel <= 18; rel++) begin
      tick();
      expect_out(int'(cyc >= c + LAT), int'(cyc >= c + LAT + RD));
    end
    reset = 1'b1;
    repeat (2) begin
      tick();
      check("rst_mid_pulse", int'(pulse), 0);
      expect_out(0, 0);
    end
    reset = 1'b0;
    q1.push_back(c + 20 + LAT);
    for (int rel = 21; rel <= 44; rel++) begin
      tick();
      expect_out(int'(cyc >= c + 20 + LAT && cyc < c + 30 + LAT), 0);
      if (rel == 30) btn_in = 1'b0;
    end
    check("rst_mid_count", cnt1, 3);
    check("rst_mid_queue", q1.size(), 0);

    // Auto-repeat disabled: one pulse per press, never held
    cnt2 = 0;
    c    = cyc;
    btn2 = 1'b1;
    q2.push_back(c + LAT);
    for (int rel = 1; rel <= 62; rel++) begin
      tick();
      check("norep_level", int'(level2), int'(cyc >= c + LAT && cyc < c + 50 + LAT));
      check("norep_held", int'(held2), 0);
      if (rel == 50) btn2 = 1'b0;
    end
    check("norep_count", cnt2, 1);
    check("norep_queue", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
